// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-memory request/response channel. The fetch unit
//               (master) drives req/addr. Memory (slave) returns gnt and
//               in-order rvalid/rdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_gnt,
        input  inst_rvalid,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_gnt,
        output inst_rvalid,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : MIPS32 instruction-fetch stage. Owns the PC and keeps at most
//               one memory request outstanding. Presents {pc, inst, valid} to
//               IF/ID through an output register backed by one hold slot.
//               Redirects on branch/jump and drops wrong-path responses.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              rst,            // asynchronous, active low
    input  wire logic              stall,
    input  wire logic              branch_flag,
    input  wire logic [ADDR_W-1:0] branch_target,
    inst_fetch_if.master           mem,
    output logic      [ADDR_W-1:0] if_pc,
    output logic      [DATA_W-1:0] if_inst,
    output logic                   if_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [ADDR_W-1:0] req_pc_q,    req_pc_d;
    logic [ADDR_W-1:0] out_pc_q,    out_pc_d;
    logic [DATA_W-1:0] out_inst_q,  out_inst_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] hold_pc_q,   hold_pc_d;
    logic [DATA_W-1:0] hold_inst_q, hold_inst_d;
    logic              hold_valid_q, hold_valid_d;

    logic              w_fire;
    logic              w_deliver;
    logic              w_consume;
    logic              w_accept;
    logic [ADDR_W-1:0] w_target;

    // A full hold slot means the output path cannot take another
    // instruction, so no new fetch is started.
    assign mem.inst_req  = (state_q == S_REQ) && !hold_valid_q;
    assign mem.inst_addr = pc_q;

    assign w_fire    = mem.inst_req && mem.inst_gnt;
    assign w_deliver = (state_q == S_WAIT) && mem.inst_rvalid;
    assign w_consume = out_valid_q && !stall;
    assign w_accept  = w_consume || !out_valid_q;
    assign w_target  = branch_target & ~ADDR_W'(3);

    assign if_pc    = out_pc_q;
    assign if_inst  = out_inst_q;
    assign if_valid = out_valid_q;

    // Next-state: fetch sequencing, output/hold delivery, then redirect override
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        out_valid_d  = out_valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;
        hold_valid_d = hold_valid_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (w_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT:  if (mem.inst_rvalid) state_d = S_REQ;
            S_DROP:  if (mem.inst_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        // The hold slot is always older than a fresh response, so it drains first.
        if (hold_valid_q && w_accept) begin
            out_pc_d     = hold_pc_q;
            out_inst_d   = hold_inst_q;
            out_valid_d  = 1'b1;
            hold_valid_d = 1'b0;
            if (w_deliver) begin
                hold_pc_d    = req_pc_q;
                hold_inst_d  = mem.inst_rdata;
                hold_valid_d = 1'b1;
            end
        end else if (w_deliver && w_accept) begin
            out_pc_d    = req_pc_q;
            out_inst_d  = mem.inst_rdata;
            out_valid_d = 1'b1;
        end else begin
            if (w_consume) out_valid_d = 1'b0;
            if (w_deliver) begin
                hold_pc_d    = req_pc_q;
                hold_inst_d  = mem.inst_rdata;
                hold_valid_d = 1'b1;
            end
        end

        // Redirect flushes everything. A granted or outstanding fetch becomes
        // a stale response that DROP must absorb.
        if (branch_flag) begin
            pc_d         = w_target;
            out_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
            case (state_q)
                S_REQ:   state_d = w_fire           ? S_DROP : S_REQ;
                S_WAIT:  state_d = mem.inst_rvalid  ? S_REQ  : S_DROP;
                S_DROP:  state_d = mem.inst_rvalid  ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            out_pc_q     <= '0;
            out_inst_q   <= '0;
            out_valid_q  <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            out_valid_q  <= out_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            hold_valid_q <= hold_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed testbench for inst_fetch. It applies a cycle-by-cycle
//               vector table and then hand-written redirect, reset and
//               wrap-around sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .mem           (bus.master),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle.
    task automatic step(input logic s, input logic br, input logic [31:0] tgt,
                        input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        stall           = s;
        branch_flag     = br;
        branch_target   = tgt;
        bus.inst_gnt    = gnt;
        bus.inst_rvalid = rv;
        bus.inst_rdata  = rd;
        #1;
    endtask

    task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc, input logic [31:0] inst);
        chk({nm, ".req"},   32'(bus.inst_req), 32'(req));
        chk({nm, ".addr"},  bus.inst_addr, addr);
        chk({nm, ".valid"}, 32'(if_valid), 32'(vld));
        if (vld) begin
            chk({nm, ".pc"},   if_pc, pc);
            chk({nm, ".inst"}, if_inst, inst);
        end
    endtask

    initial begin
        bus.inst_gnt    = 1'b0;
        bus.inst_rvalid = 1'b0;
        bus.inst_rdata  = '0;

        //          stall br tgt         gnt rv rdata          req addr          vld pc            inst
        vecs[0]  = '{1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b0,32'h0,   1'b0,32'h0,   32'h0};
        vecs[1]  = '{1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b1,32'h0,   1'b0,32'h0,   32'h0};
        vecs[2]  = '{1'b0,1'b0,32'h0,    1'b0,1'b1,32'h2408_0001,1'b0,32'h4,   1'b0,32'h0,   32'h0};
        vecs[3]  = '{1'b1,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b1,32'h4,   1'b1,32'h0,   32'h2408_0001};
        vecs[4]  = '{1'b1,1'b0,32'h0,    1'b0,1'b1,32'h2408_0005,1'b0,32'h8,   1'b1,32'h0,   32'h2408_0001};
        vecs[5]  = '{1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b0,32'h8,   1'b1,32'h0,   32'h2408_0001};
        vecs[6]  = '{1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b0,32'h8,   1'b1,32'h0,   32'h2408_0001};
        vecs[7]  = '{1'b1,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b0,32'h8,   1'b1,32'h0,   32'h2408_0001};
        vecs[8]  = '{1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b0,32'h8,   1'b1,32'h0,   32'h2408_0001};
        vecs[9]  = '{1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b1,32'h8,   1'b1,32'h4,   32'h2408_0005};
        vecs[10] = '{1'b0,1'b1,32'h100,  1'b0,1'b0,32'h0,        1'b0,32'hC,   1'b0,32'h0,   32'h0};
        vecs[11] = '{1'b0,1'b0,32'h0,    1'b0,1'b1,32'h2408_0009,1'b0,32'h100, 1'b0,32'h0,   32'h0};
        vecs[12] = '{1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b1,32'h100, 1'b0,32'h0,   32'h0};
        vecs[13] = '{1'b0,1'b0,32'h0,    1'b1,1'b0,32'h0,        1'b1,32'h100, 1'b0,32'h0,   32'h0};
        vecs[14] = '{1'b0,1'b0,32'h0,    1'b0,1'b1,32'h2408_0101,1'b0,32'h104, 1'b0,32'h0,   32'h0};
        vecs[15] = '{1'b0,1'b0,32'h0,    1'b0,1'b0,32'h0,        1'b1,32'h104, 1'b1,32'h100, 32'h2408_0101};

        // Reset state
        #1 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("reset.pc",   if_pc,   32'h0);
        chk("reset.inst", if_inst, 32'h0);
        #1 rst = 1'b1;

        // Basic fetch, stall with hold slot, redirect in WAIT
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            chk_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld,
                    vecs[i].pc, vecs[i].inst);
        end

        // Redirect coincident with rvalid in WAIT: response never surfaces
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_out("brrv.req104", 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h302, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk_out("brrv.wait", 1'b0, 32'h108, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_out("brrv.after", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);

        // Redirect coincident with gnt: granted fetch is dropped
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        chk_out("brgnt.req", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0300);
        chk_out("brgnt.drop", 1'b0, 32'h200, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_out("brgnt.req200", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2408_0201);
        chk_out("brgnt.wait", 1'b0, 32'h204, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_out("brgnt.deliv", 1'b1, 32'h204, 1'b1, 32'h200, 32'h2408_0201);

        // Asynchronous reset in the middle of WAIT
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_out("areset.pre", 1'b0, 32'h208, 1'b1, 32'h200, 32'h2408_0201);
        #1 rst = 1'b0;
        #1;
        chk_out("areset.now", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("areset.pc",   if_pc,   32'h0);
        chk("areset.inst", if_inst, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk_out("areset.idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_out("areset.req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // Unaligned target forced to word boundary, PC wrap at top of memory
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        chk_out("wrap.br", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_out("wrap.req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        chk_out("wrap.wait", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_out("wrap.deliv", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
